// File: rtl/writeback_pkg.sv
// Shared types and constants for the writeback stage: FSM states and load funct3 encodings.
package writeback_pkg;

    typedef enum logic [0:0] {
        StIdle,
        StWaitMem
    } wb_state_e;

    localparam logic [2:0] F3_LB  = 3'd0;
    localparam logic [2:0] F3_LH  = 3'd1;
    localparam logic [2:0] F3_LW  = 3'd2;
    localparam logic [2:0] F3_LBU = 3'd4;
    localparam logic [2:0] F3_LHU = 3'd5;

endpackage

// File: rtl/load_extend.sv
// Selects the byte/half/word addressed by a load from an aligned memory word and extends it.
module load_extend
    import writeback_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic [2:0]      funct3,
    input  logic [1:0]      addr,
    input  logic [XLEN-1:0] rdata,
    output logic [XLEN-1:0] value,
    output logic            illegal
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = rdata[{addr, 3'b000} +: 8];
        half_sel = rdata[{addr[1], 4'b0000} +: 16];
        value    = '0;
        illegal  = 1'b0;
        case (funct3)
            F3_LB:   value = {{(XLEN-8){byte_sel[7]}}, byte_sel};
            F3_LH:   value = {{(XLEN-16){half_sel[15]}}, half_sel};
            F3_LW:   value = rdata;
            F3_LBU:  value = {{(XLEN-8){1'b0}}, byte_sel};
            F3_LHU:  value = {{(XLEN-16){1'b0}}, half_sel};
            default: illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/writeback_stage.sv
// Writeback stage: registers ALU results into the register file and waits for load data,
// extracting and extending the addressed byte/half/word before writing it back.
module writeback_stage
    import writeback_pkg::*;
#(
    parameter int unsigned XLEN       = 32,
    parameter int unsigned REG_ADDR_W = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ex_valid,
    output logic                  ex_ready,
    input  logic [REG_ADDR_W-1:0] ex_rd,
    input  logic                  ex_wb_en,
    input  logic [XLEN-1:0]       ex_result,
    input  logic                  ex_is_load,
    input  logic [2:0]            ex_funct3,
    input  logic                  mem_rvalid,
    input  logic [XLEN-1:0]       mem_rdata,
    output logic [REG_ADDR_W-1:0] write_address,
    output logic                  write_enable,
    output logic [XLEN-1:0]       write_data,
    output logic                  pending_valid,
    output logic [REG_ADDR_W-1:0] pending_rd,
    output logic                  load_fault
);

    wb_state_e             state_q;
    logic [REG_ADDR_W-1:0] ld_rd_q;
    logic                  ld_wb_en_q;
    logic [2:0]            ld_funct3_q;
    logic [1:0]            ld_addr_q;

    logic [XLEN-1:0] ld_value;
    logic            ld_illegal;
    logic            accept;

    assign ex_ready = (state_q == StIdle);
    assign accept   = ex_valid && ex_ready;

    load_extend #(
        .XLEN (XLEN)
    ) u_load_extend (
        .funct3  (ld_funct3_q),
        .addr    (ld_addr_q),
        .rdata   (mem_rdata),
        .value   (ld_value),
        .illegal (ld_illegal)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= StIdle;
            write_enable  <= 1'b0;
            write_address <= '0;
            write_data    <= '0;
            pending_valid <= 1'b0;
            pending_rd    <= '0;
            load_fault    <= 1'b0;
            ld_rd_q       <= '0;
            ld_wb_en_q    <= 1'b0;
            ld_funct3_q   <= '0;
            ld_addr_q     <= '0;
        end else begin
            write_enable <= 1'b0;
            load_fault   <= 1'b0;
            if (state_q == StIdle) begin
                if (accept && ex_is_load) begin
                    ld_rd_q       <= ex_rd;
                    ld_wb_en_q    <= ex_wb_en;
                    ld_funct3_q   <= ex_funct3;
                    ld_addr_q     <= ex_result[1:0];
                    pending_valid <= 1'b1;
                    pending_rd    <= ex_rd;
                    state_q       <= StWaitMem;
                end else if (accept && ex_wb_en && (ex_rd != '0)) begin
                    write_enable  <= 1'b1;
                    write_address <= ex_rd;
                    write_data    <= ex_result;
                end
            end else if (mem_rvalid) begin
                // Address/data only move on a real write so they hold otherwise.
                pending_valid <= 1'b0;
                state_q       <= StIdle;
                if (ld_illegal) begin
                    load_fault <= 1'b1;
                end else if (ld_wb_en_q && (ld_rd_q != '0)) begin
                    write_enable  <= 1'b1;
                    write_address <= ld_rd_q;
                    write_data    <= ld_value;
                end
            end
        end
    end

endmodule

// File: tb/tb_writeback_stage.sv
// Self-checking bench for writeback_stage: directed cases followed by randomized instructions.
module tb_writeback_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        ex_valid;
    logic        ex_ready;
    logic [4:0]  ex_rd;
    logic        ex_wb_en;
    logic [31:0] ex_result;
    logic        ex_is_load;
    logic [2:0]  ex_funct3;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;
    logic [4:0]  write_address;
    logic        write_enable;
    logic [31:0] write_data;
    logic        pending_valid;
    logic [4:0]  pending_rd;
    logic        load_fault;

    int total = 0;
    int bad   = 0;

    // Last value written to the register file, as the outputs should hold it.
    logic [4:0]  m_addr;
    logic [31:0] m_data;

    always #5 clk = ~clk;

    writeback_stage #(
        .XLEN       (32),
        .REG_ADDR_W (5)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .ex_valid      (ex_valid),
        .ex_ready      (ex_ready),
        .ex_rd         (ex_rd),
        .ex_wb_en      (ex_wb_en),
        .ex_result     (ex_result),
        .ex_is_load    (ex_is_load),
        .ex_funct3     (ex_funct3),
        .mem_rvalid    (mem_rvalid),
        .mem_rdata     (mem_rdata),
        .write_address (write_address),
        .write_enable  (write_enable),
        .write_data    (write_data),
        .pending_valid (pending_valid),
        .pending_rd    (pending_rd),
        .load_fault    (load_fault)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference load semantics written with plain shifts and arithmetic.
    function automatic logic [31:0] ref_load(input int f3, input int a, input logic [31:0] w,
                                             output bit illegal);
        longint unsigned b = (longint'(w) >> (8 * a)) % 256;
        longint unsigned h = (longint'(w) >> (16 * (a / 2))) % 65536;
        illegal = 0;
        case (f3)
            0:       return (b >= 128) ? 32'(b + 64'hFFFF_FF00) : 32'(b);
            1:       return (h >= 32768) ? 32'(h + 64'hFFFF_0000) : 32'(h);
            2:       return w;
            4:       return 32'(b);
            5:       return 32'(h);
            default: begin illegal = 1; return 32'd0; end
        endcase
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_hold(input string tag);
        check({tag, ".we"}, {31'd0, write_enable}, 32'd0);
        check({tag, ".addr_hold"}, {27'd0, write_address}, {27'd0, m_addr});
        check({tag, ".data_hold"}, write_data, m_data);
    endtask

    // Issues one instruction (called #1 after an edge) and checks its writeback.
    task automatic run_op(input bit is_load, input logic [4:0] rd, input bit wb_en,
                          input logic [31:0] result, input logic [2:0] f3,
                          input int waits, input logic [31:0] rdata, input bit idle_rvalid);
        bit          ill;
        bit          do_write;
        logic [31:0] exp_val;
        check("ready_before", {31'd0, ex_ready}, 32'd1);
        ex_valid   = 1'b1;
        ex_rd      = rd;
        ex_wb_en   = wb_en;
        ex_result  = result;
        ex_is_load = is_load;
        ex_funct3  = f3;
        mem_rvalid = idle_rvalid;
        mem_rdata  = $urandom;
        tick();
        ex_valid   = 1'b0;
        mem_rvalid = 1'b0;
        if (!is_load) begin
            do_write = wb_en && (rd != 0);
            if (do_write) begin
                m_addr = rd;
                m_data = result;
                check("alu.we", {31'd0, write_enable}, 32'd1);
                check("alu.addr", {27'd0, write_address}, {27'd0, m_addr});
                check("alu.data", write_data, m_data);
            end else begin
                check_hold("alu_nowrite");
            end
            check("alu.pending", {31'd0, pending_valid}, 32'd0);
            return;
        end
        check("ld.ready_low", {31'd0, ex_ready}, 32'd0);
        check("ld.pending_valid", {31'd0, pending_valid}, 32'd1);
        check("ld.pending_rd", {27'd0, pending_rd}, {27'd0, rd});
        // A competing instruction sits on the bus while the load waits; it must not be taken.
        ex_valid   = 1'b1;
        ex_is_load = 1'b0;
        ex_wb_en   = 1'b1;
        ex_rd      = 5'd31;
        ex_result  = 32'hDEAD_BEEF;
        for (int i = 0; i < waits; i++) begin
            tick();
            check("wait.ready_low", {31'd0, ex_ready}, 32'd0);
            check("wait.pending_rd", {27'd0, pending_rd}, {27'd0, rd});
            check_hold("wait");
        end
        mem_rvalid = 1'b1;
        mem_rdata  = rdata;
        tick();
        mem_rvalid = 1'b0;
        ex_valid   = 1'b0;
        exp_val    = ref_load(int'(f3), int'(result[1:0]), rdata, ill);
        do_write   = !ill && wb_en && (rd != 0);
        check("ld.fault", {31'd0, load_fault}, {31'd0, ill});
        check("ld.pending_clear", {31'd0, pending_valid}, 32'd0);
        check("ld.ready_back", {31'd0, ex_ready}, 32'd1);
        if (do_write) begin
            m_addr = rd;
            m_data = exp_val;
            check("ld.we", {31'd0, write_enable}, 32'd1);
            check("ld.addr", {27'd0, write_address}, {27'd0, m_addr});
            check("ld.data", write_data, m_data);
        end else begin
            check_hold("ld_nowrite");
        end
        tick();
        check_hold("ld_after");
        check("ld_after.fault", {31'd0, load_fault}, 32'd0);
    endtask

    initial begin
        rst        = 1'b1;
        ex_valid   = 1'b0;
        ex_rd      = '0;
        ex_wb_en   = 1'b0;
        ex_result  = '0;
        ex_is_load = 1'b0;
        ex_funct3  = '0;
        mem_rvalid = 1'b0;
        mem_rdata  = '0;
        m_addr     = '0;
        m_data     = '0;
        tick();
        tick();
        rst = 1'b0;
        check("rst.ready", {31'd0, ex_ready}, 32'd1);
        check("rst.pending_valid", {31'd0, pending_valid}, 32'd0);
        check("rst.pending_rd", {27'd0, pending_rd}, 32'd0);
        check("rst.fault", {31'd0, load_fault}, 32'd0);
        check_hold("rst");

        // Directed cases.
        run_op(0, 5'd5, 1, 32'h0000_1234, 3'd0, 0, 32'd0, 0);
        run_op(1, 5'd3, 1, 32'h0000_1003, 3'd0, 4, 32'h80AB_CDEF, 0);
        check("lb.value", m_data, 32'hFFFF_FF80);
        run_op(1, 5'd7, 1, 32'h0000_2002, 3'd5, 1, 32'h8001_0000, 0);
        check("lhu.value", m_data, 32'h0000_8001);
        run_op(0, 5'd0, 1, 32'h1111_1111, 3'd0, 0, 32'd0, 0);
        run_op(1, 5'd9, 0, 32'h0000_0000, 3'd2, 2, 32'h1234_5678, 0);
        run_op(1, 5'd4, 1, 32'h0000_0001, 3'd3, 1, 32'hFFFF_FFFF, 0);
        // Back-to-back ALU writes, one with a stray mem_rvalid while idle.
        run_op(0, 5'd1, 1, 32'hA5A5_0001, 3'd0, 0, 32'd0, 0);
        run_op(0, 5'd2, 1, 32'hA5A5_0002, 3'd0, 0, 32'd0, 1);
        run_op(0, 5'd3, 1, 32'hA5A5_0003, 3'd0, 0, 32'd0, 0);

        // Reset while a load waits: load is abandoned and its late data ignored.
        ex_valid   = 1'b1;
        ex_is_load = 1'b1;
        ex_rd      = 5'd12;
        ex_wb_en   = 1'b1;
        ex_funct3  = 3'd2;
        ex_result  = 32'h0;
        tick();
        ex_valid = 1'b0;
        tick();
        check("rstw.pending", {31'd0, pending_valid}, 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        m_addr = '0;
        m_data = '0;
        check("rstw.ready", {31'd0, ex_ready}, 32'd1);
        check("rstw.pending_valid", {31'd0, pending_valid}, 32'd0);
        check("rstw.pending_rd", {27'd0, pending_rd}, 32'd0);
        check_hold("rstw");
        mem_rvalid = 1'b1;
        mem_rdata  = 32'hCAFE_F00D;
        tick();
        mem_rvalid = 1'b0;
        check_hold("rstw_late");
        check("rstw_late.fault", {31'd0, load_fault}, 32'd0);
        check("rstw_late.ready", {31'd0, ex_ready}, 32'd1);

        // Randomized mix, illegal funct3 and rd=0 included.
        for (int n = 0; n < 60; n++) begin
            run_op(bit'($urandom_range(0, 1)), 5'($urandom_range(0, 31)),
                   bit'($urandom_range(0, 3) != 0), $urandom, 3'($urandom_range(0, 7)),
                   int'($urandom_range(0, 3)), $urandom, bit'($urandom_range(0, 1)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/writeback_stage.md
WRITEBACK_STAGE -- requirements
Module: writeback_stage

Interface
REQ-001 SHALL have parameter XLEN, default 32, meaning data and result width.
REQ-002 SHALL have parameter REG_ADDR_W, default 5, meaning destination register index width.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  reset; synchronous and active-high.
REQ-005 SHALL have port ex_valid  input  1  execute stage presents an instruction.
REQ-006 SHALL have port ex_ready  output  1  stage accepts the instruction this cycle.
REQ-007 SHALL have port ex_rd  input  REG_ADDR_W  destination register.
REQ-008 SHALL have port ex_wb_en  input  1  instruction writes a register.
REQ-009 SHALL have port ex_result  input  XLEN  ALU result; for loads, the byte address.
REQ-010 SHALL have port ex_is_load  input  1  instruction is a load.
REQ-011 SHALL have port ex_funct3  input  3  load size/sign (0 LB, 1 LH, 2 LW, 4 LBU, 5 LHU).
REQ-012 SHALL have port mem_rvalid  input  1  load data valid (single-cycle pulse).
REQ-013 SHALL have port mem_rdata  input  XLEN  aligned word from memory.
REQ-014 SHALL have port write_address  output  REG_ADDR_W  register-file write index.
REQ-015 SHALL have port write_enable  output  1  register-file write strobe.
REQ-016 SHALL have port write_data  output  XLEN  register-file write value.
REQ-017 SHALL have port pending_valid / pending_rd  output  1 / REG_ADDR_W  load in flight and its destination, for hazard stall.
REQ-018 SHALL have port load_fault  output  1  one-cycle pulse on illegal load funct3.

Function
REQ-019 SHALL implement FSM states IDLE and WAIT_MEM; ex_ready = (state == IDLE), combinational.
REQ-020 SHALL accept an instruction on ex_valid && ex_ready (a handshake).
REQ-021 Non-load accepted: write_enable, write_address, write_data SHALL be registered and asserted exactly one cycle after acceptance, with write_data = ex_result; state stays IDLE.
REQ-022 Load accepted: SHALL latch rd, wb_en, funct3, result[1:0]; go to WAIT_MEM; pending_valid=1, pending_rd=latched rd.
REQ-023 In WAIT_MEM on mem_rvalid: SHALL write the extracted value one cycle later, return to IDLE, and clear pending_valid in that same cycle.
REQ-024 Extraction: LB/LBU select byte addr[1:0]; LH/LHU select half addr[1]; LW whole word ignoring addr; LB/LH sign-extend, LBU/LHU zero-extend.
REQ-025 Illegal funct3 (3,6,7) on a load: SHALL suppress the write and pulse load_fault together with the would-be write cycle.
REQ-026 rd == 0 or wb_en == 0: SHALL suppress write_enable; the load still waits for mem_rvalid.
REQ-027 write_enable SHALL be high for exactly one cycle per write; write_address and write_data hold their last value otherwise.
REQ-028 mem_rvalid in IDLE SHALL be ignored; ex_valid in WAIT_MEM SHALL NOT be accepted even if mem_rvalid is high that cycle.
REQ-029 Back-to-back non-loads SHALL sustain one write per cycle.

Reset
REQ-030 On rst: state=IDLE, write_enable=0, write_address=0, write_data=0, pending_valid=0, pending_rd=0, load_fault=0.
REQ-031 Reset during WAIT_MEM SHALL abandon the load with no write; a subsequent late mem_rvalid SHALL be ignored.

Structure
REQ-032 A shared package writeback_pkg SHALL hold the state enum and the load funct3 constants.
REQ-033 Byte/half extraction SHALL be a combinational sub-module load_extend (inputs funct3, addr[1:0], rdata; outputs value and illegal).

Verification
REQ-034 ADD to rd=5, result=0x0000_1234 -> next cycle write_enable=1, write_address=5, write_data=0x0000_1234.
REQ-035 LB rd=3, addr low=2'b11, mem_rdata=0x80AB_CDEF after 4 wait cycles -> ex_ready low throughout, pending_rd=3; write 0xFFFF_FF80 one cycle after mem_rvalid.
REQ-036 LHU rd=7, addr low=2'b10, mem_rdata=0x8001_0000 -> write_data=0x0000_8001.
REQ-037 Non-load with rd=0, then LW with wb_en=0 -> write_enable never asserts; the load completes normally.
REQ-038 Load with funct3=3 -> load_fault pulse one cycle after mem_rvalid, no write.
REQ-039 rst asserted in WAIT_MEM, then mem_rvalid -> no write, ex_ready=1, pending_valid=0.
